// File: rtl/cgra_pkg.sv
// cgra_pkg: FSM state type, default BRAM geometry and a state helper shared by
// cgra_mem_if and its per-port register stage.
package cgra_pkg;

    localparam int CGRA_DWIDTH   = 32;
    localparam int CGRA_AWIDTH   = 10;
    localparam int CGRA_BYTE_LEN = CGRA_DWIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } cgra_state_e;

    // States in which CGRA memory traffic reaches the BRAM.
    function automatic logic is_fwd_state(input cgra_state_e st);
        return (st == ST_WAIT_BUSY) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/cgra_mem_port.sv
// cgra_mem_port: one-cycle register stage between one CGRA data channel and
// one BRAM port. Enable and byte-write-enables are cleared whenever the
// controller is not forwarding; address and data hold their last value.
module cgra_mem_port
    import cgra_pkg::*;
#(
    parameter int DWIDTH   = CGRA_DWIDTH,
    parameter int AWIDTH   = CGRA_AWIDTH,
    parameter int BYTE_LEN = CGRA_BYTE_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fwd,
    input  logic                cgra_en,
    input  logic [BYTE_LEN-1:0] cgra_wen,
    input  logic [AWIDTH-1:0]   cgra_addr,
    input  logic [DWIDTH-1:0]   cgra_wdata,
    output logic                bram_en,
    output logic [BYTE_LEN-1:0] bram_wen,
    output logic [AWIDTH-1:0]   bram_addr,
    output logic [DWIDTH-1:0]   bram_wdata
);

    logic                en_q, en_d;
    logic [BYTE_LEN-1:0] wen_q, wen_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;

    // Capture the request only when it will be presented in a forwarding state.
    always_comb begin
        en_d    = 1'b0;
        wen_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (fwd) begin
            en_d    = cgra_en;
            wen_d   = cgra_wen;
            addr_d  = cgra_addr;
            wdata_d = cgra_wdata;
        end
    end

    // Register stage, synchronous active-low reset clears every output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            en_q    <= en_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bram_en    = en_q;
    assign bram_wen   = wen_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

endmodule

// File: rtl/cgra_mem_if.sv
// cgra_mem_if: run controller and BRAM bridge for a CGRA PE array.
// A rising edge on Computation_Start issues a one-cycle PE_Start, waits up to
// BUSY_TIMEOUT cycles for PE_Array_Busy, follows the run until Busy drops and
// then holds Computation_Done until software lowers Start. CGRA memory
// channels reach the BRAM only while waiting for or running the array.
// Optional feature: define CGRA_MEM_IF_CYCLE_CNT_EN to build the Run_Cycles
// counter; otherwise Run_Cycles is constant 0.
module cgra_mem_if
    import cgra_pkg::*;
#(
    parameter int DWIDTH       = CGRA_DWIDTH,
    parameter int AWIDTH       = CGRA_AWIDTH,
    parameter int NUM_PORTS    = 2,
    parameter int BYTE_LEN     = CGRA_BYTE_LEN,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          Clk,
    input  logic                          Resetn,
    input  logic                          Computation_Start,
    output logic                          Computation_Done,
    output logic                          Computation_Error,
    output logic                          PE_Start,
    input  logic                          PE_Array_Busy,
    input  logic [NUM_PORTS-1:0]          Cgra_En,
    input  logic [NUM_PORTS*BYTE_LEN-1:0] Cgra_Wen,
    input  logic [NUM_PORTS*AWIDTH-1:0]   Cgra_Addr,
    input  logic [NUM_PORTS*DWIDTH-1:0]   Cgra_Wdata,
    output logic [NUM_PORTS*DWIDTH-1:0]   Cgra_Rdata,
    output logic [NUM_PORTS-1:0]          Bram_En,
    output logic [NUM_PORTS*BYTE_LEN-1:0] Bram_Wen,
    output logic [NUM_PORTS*AWIDTH-1:0]   Bram_Addr,
    output logic [NUM_PORTS*DWIDTH-1:0]   Bram_Wdata,
    input  logic [NUM_PORTS*DWIDTH-1:0]   Bram_Rdata,
    output logic [31:0]                   Run_Cycles
);

    // Wide enough to hold BUSY_TIMEOUT itself.
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    cgra_state_e   state_q, state_d;
    logic          start_prev_q, start_prev_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          fwd;

    // Next-state logic; wait_cnt counts cycles since the PE_Start pulse.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        wait_cnt_d   = wait_cnt_q;
        start_prev_d = Computation_Start;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (Computation_Start && !start_prev_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wait_cnt_d = TW'(1);
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (PE_Array_Busy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q >= TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (!PE_Array_Busy) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (!Computation_Start) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Controller registers; the edge detector loads 1 so a held Start is ignored.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign PE_Start          = (state_q == ST_START);
    assign Computation_Done  = (state_q == ST_DONE);
    assign Computation_Error = err_q;

    // Keyed on the next state so Bram_En/Wen are never seen outside WAIT_BUSY/RUN.
    assign fwd = is_fwd_state(state_d);

    assign Cgra_Rdata = Bram_Rdata;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        cgra_mem_port #(
            .DWIDTH   (DWIDTH),
            .AWIDTH   (AWIDTH),
            .BYTE_LEN (BYTE_LEN)
        ) u_port (
            .clk        (Clk),
            .rst_n      (Resetn),
            .fwd        (fwd),
            .cgra_en    (Cgra_En[i]),
            .cgra_wen   (Cgra_Wen[i*BYTE_LEN +: BYTE_LEN]),
            .cgra_addr  (Cgra_Addr[i*AWIDTH +: AWIDTH]),
            .cgra_wdata (Cgra_Wdata[i*DWIDTH +: DWIDTH]),
            .bram_en    (Bram_En[i]),
            .bram_wen   (Bram_Wen[i*BYTE_LEN +: BYTE_LEN]),
            .bram_addr  (Bram_Addr[i*AWIDTH +: AWIDTH]),
            .bram_wdata (Bram_Wdata[i*DWIDTH +: DWIDTH])
        );
    end

`ifdef CGRA_MEM_IF_CYCLE_CNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    // Clear when a run starts, count WAIT_BUSY/RUN cycles, saturate, else hold.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if ((state_q == ST_IDLE) && (state_d == ST_START)) begin
            run_cycles_d = '0;
        end else if (is_fwd_state(state_q) && (run_cycles_q != '1)) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    // Run-cycle counter register.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign Run_Cycles = run_cycles_q;
`else
    assign Run_Cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cgra_mem_if.sv
// tb_cgra_mem_if: randomized and directed stimulus for cgra_mem_if with four
// ports. A timeline model predicts, from the rules of a run, when PE_Start and
// Done change and which cycles forward CGRA traffic; a monitor compares every
// cycle against the expected queues.
module tb_cgra_mem_if;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BL = 4;
    localparam int TO = 16;

    localparam int K_PE   = 0;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;

    typedef struct {
        int            cyc;
        int            port;
        logic          en;
        logic [BL-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } port_exp_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic        err;
        logic [31:0] rc;
    } ctl_exp_t;

    logic               clk;
    logic               Resetn;
    logic               Computation_Start;
    logic               Computation_Done;
    logic               Computation_Error;
    logic               PE_Start;
    logic               PE_Array_Busy;
    logic [NP-1:0]      Cgra_En;
    logic [NP*BL-1:0]   Cgra_Wen;
    logic [NP*AW-1:0]   Cgra_Addr;
    logic [NP*DW-1:0]   Cgra_Wdata;
    logic [NP*DW-1:0]   Cgra_Rdata;
    logic [NP-1:0]      Bram_En;
    logic [NP*BL-1:0]   Bram_Wen;
    logic [NP*AW-1:0]   Bram_Addr;
    logic [NP*DW-1:0]   Bram_Wdata;
    logic [NP*DW-1:0]   Bram_Rdata;
    logic [31:0]        Run_Cycles;

    logic [NP*DW-1:0]   rdata_drv;
    port_exp_t          port_q[$];
    ctl_exp_t           ctl_q[$];
    int                 cyc = 0;
    int                 checks = 0;
    int                 errors = 0;
    logic               mon_en = 1'b0;
    logic               prev_done = 1'b0;

    cgra_mem_if #(
        .DWIDTH       (DW),
        .AWIDTH       (AW),
        .NUM_PORTS    (NP),
        .BYTE_LEN     (BL),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .Clk               (clk),
        .Resetn            (Resetn),
        .Computation_Start (Computation_Start),
        .Computation_Done  (Computation_Done),
        .Computation_Error (Computation_Error),
        .PE_Start          (PE_Start),
        .PE_Array_Busy     (PE_Array_Busy),
        .Cgra_En           (Cgra_En),
        .Cgra_Wen          (Cgra_Wen),
        .Cgra_Addr         (Cgra_Addr),
        .Cgra_Wdata        (Cgra_Wdata),
        .Cgra_Rdata        (Cgra_Rdata),
        .Bram_En           (Bram_En),
        .Bram_Wen          (Bram_Wen),
        .Bram_Addr         (Bram_Addr),
        .Bram_Wdata        (Bram_Wdata),
        .Bram_Rdata        (Bram_Rdata),
        .Run_Cycles        (Run_Cycles)
    );

    // Clock and cycle index (cycle k is the interval after the k-th rising edge).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected Run_Cycles for a run with n forwarding cycles.
    function automatic logic [31:0] rc_exp(input int n);
`ifdef CGRA_MEM_IF_CYCLE_CNT_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    task automatic push_ctl(input int c, input int kind, input logic err, input logic [31:0] rc);
        ctl_q.push_back('{c, kind, err, rc});
    endtask

    // Drive one cycle of CGRA traffic; if cycle k+1 falls inside the forwarding
    // window [p+1, last], the registered copy is expected there.
    task automatic drive_traffic(input int k, input int p, input int last, input int mode);
        logic          en;
        logic [BL-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        for (int i = 0; i < NP; i++) begin
            case (mode)
                0: begin en = 1'b0; wen = '0; addr = '0; wd = '0; end
                3: begin en = 1'b1; wen = '1; addr = AW'($urandom); wd = $urandom; end
                4: begin en = 1'b1; wen = 4'hF; addr = 10'h3FF; wd = 32'hA5A5_0000 + DW'(i); end
                default: begin
                    en   = 1'($urandom_range(0, 1));
                    wen  = BL'($urandom_range(0, 15));
                    addr = AW'($urandom);
                    wd   = $urandom;
                end
            endcase
            Cgra_En[i]             = en;
            Cgra_Wen[i*BL +: BL]   = wen;
            Cgra_Addr[i*AW +: AW]  = addr;
            Cgra_Wdata[i*DW +: DW] = wd;
            if ((k + 1 >= p + 1) && (k + 1 <= last)) begin
                port_q.push_back('{k + 1, i, en, wen, addr, wd});
            end
        end
        rdata_drv  = {$urandom, $urandom, $urandom, $urandom};
        Bram_Rdata = rdata_drv;
    endtask

    task automatic idle(input int n, input int mode);
        repeat (n) begin
            @(negedge clk);
            Computation_Start = 1'b0;
            PE_Array_Busy     = 1'b0;
            drive_traffic(0, -100, -100, mode);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pe_start"}, PE_Start, '0);
        chk({tag, "_done"}, Computation_Done, '0);
        chk({tag, "_error"}, Computation_Error, '0);
        chk({tag, "_run_cycles"}, Run_Cycles, '0);
        chk({tag, "_bram_en"}, Bram_En, '0);
        chk({tag, "_bram_wen"}, Bram_Wen, '0);
        chk({tag, "_bram_addr"}, Bram_Addr, '0);
        chk({tag, "_bram_wdata"}, Bram_Wdata, '0);
    endtask

    // One run. r: cycles after PE_Start at which Busy is driven high (0 = never),
    // f: cycle after PE_Start at which Busy is driven low again, x_rel: cycle after
    // PE_Start at which Start is lowered, dir_at: cycle of the all-port write (0 = none).
    task automatic do_run(input int r, input int f, input int x_rel, input int dir_at);
        int   s, p, d, act, x, fall;
        logic err;
        @(negedge clk);
        s = cyc;
        p = s + 1;
        if (r == 0) begin
            act = TO - 1;
            d   = p + TO;
            err = 1'b1;
        end else begin
            act = f;
            d   = p + f + 1;
            err = 1'b0;
        end
        x    = p + x_rel;
        fall = ((d > x) ? d : x) + 1;
        push_ctl(p, K_PE, 1'b0, 32'd0);
        push_ctl(d, K_RISE, err, rc_exp(act));
        push_ctl(fall, K_FALL, 1'b0, rc_exp(act));
        for (int k = s; k <= fall; k++) begin
            if (k != s) @(negedge clk);
            Computation_Start = (k < x);
            PE_Array_Busy     = (r != 0) && (k >= p + r) && (k < p + f);
            drive_traffic(k, p, p + act, ((dir_at > 0) && (k == p + dir_at)) ? 4 : 1);
        end
    endtask

    // Reset pulse in the middle of a run with Start held high throughout.
    task automatic reset_mid_run();
        int s, p;
        @(negedge clk);
        s = cyc;
        p = s + 1;
        push_ctl(p, K_PE, 1'b0, 32'd0);
        for (int k = s; k <= p + 8; k++) begin
            if (k != s) @(negedge clk);
            Computation_Start = 1'b1;
            PE_Array_Busy     = (k >= p + 3);
            drive_traffic(k, p, p + 8, 1);
        end
        Resetn = 1'b0;
        @(negedge clk);
        Resetn        = 1'b1;
        PE_Array_Busy = 1'b0;
        drive_traffic(0, -100, -100, 0);
        check_zero("mid_run_reset");
        repeat (6) begin
            @(negedge clk);
            drive_traffic(0, -100, -100, 1);
        end
    endtask

    // Monitor: compares every cycle against the expected queues.
    always @(posedge clk) begin
        logic     obs [3];
        logic     exp_k;
        port_exp_t pe;
        ctl_exp_t  ce;
        #1;
        if (mon_en) begin
            for (int i = 0; i < NP; i++) begin
                while ((port_q.size() > 0) && (port_q[0].cyc < cyc)) begin
                    pe = port_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL port_missed port %0d due cycle %0d, now %0d", pe.port, pe.cyc, cyc);
                end
                if ((port_q.size() > 0) && (port_q[0].cyc == cyc) && (port_q[0].port == i)) begin
                    pe = port_q.pop_front();
                    chk($sformatf("bram_en[%0d]", i), Bram_En[i], pe.en);
                    chk($sformatf("bram_wen[%0d]", i), Bram_Wen[i*BL +: BL], pe.wen);
                    chk($sformatf("bram_addr[%0d]", i), Bram_Addr[i*AW +: AW], pe.addr);
                    chk($sformatf("bram_wdata[%0d]", i), Bram_Wdata[i*DW +: DW], pe.wdata);
                end else begin
                    chk($sformatf("idle_bram_en[%0d]", i), Bram_En[i], '0);
                    chk($sformatf("idle_bram_wen[%0d]", i), Bram_Wen[i*BL +: BL], '0);
                end
            end
            chk("cgra_rdata", Cgra_Rdata, rdata_drv);

            obs[K_PE]   = PE_Start;
            obs[K_RISE] = Computation_Done && !prev_done;
            obs[K_FALL] = !Computation_Done && prev_done;
            prev_done   = Computation_Done;
            while ((ctl_q.size() > 0) && (ctl_q[0].cyc < cyc)) begin
                ce = ctl_q.pop_front();
                checks++;
                errors++;
                $display("FAIL ctl_missed kind %0d due cycle %0d, now %0d", ce.kind, ce.cyc, cyc);
            end
            for (int kind = 0; kind < 3; kind++) begin
                exp_k = (ctl_q.size() > 0) && (ctl_q[0].cyc == cyc) && (ctl_q[0].kind == kind);
                chk($sformatf("ctl_event_%0d", kind), obs[kind], exp_k);
                if (exp_k) begin
                    ce = ctl_q.pop_front();
                    if (kind == K_RISE) chk("done_error", Computation_Error, ce.err);
                    chk($sformatf("run_cycles_%0d", kind), Run_Cycles, ce.rc);
                end
            end
            if (!Computation_Done) chk("error_without_done", Computation_Error, '0);
        end
    end

    // Stimulus sequence.
    initial begin
        int r, f, x_rel, dir;
        Resetn            = 1'b0;
        Computation_Start = 1'b1;
        PE_Array_Busy     = 1'b0;
        Cgra_En           = '0;
        Cgra_Wen          = '0;
        Cgra_Addr         = '0;
        Cgra_Wdata        = '0;
        rdata_drv         = '0;
        Bram_Rdata        = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        Resetn = 1'b1;
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            drive_traffic(0, -100, -100, 1);
        end
        idle(3, 1);
        do_run(4, 24, 27, 6);
        idle(2, 1);
        do_run(0, 0, 5, 0);
        idle(2, 0);
        idle(3, 3);
        do_run(2, 10, 40, 5);
        idle(2, 1);
        reset_mid_run();
        idle(2, 1);
        for (int n = 0; n < 6; n++) begin
            r     = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
            f     = r + $urandom_range(2, 20);
            x_rel = $urandom_range(1, ((r == 0) ? TO : f) + 8);
            dir   = (r == 0) ? 0 : r + 1;
            do_run(r, f, x_rel, dir);
            idle($urandom_range(1, 4), 1);
        end
        idle(5, 0);
        chk("port_queue_drained", 128'(port_q.size()), '0);
        chk("ctl_queue_drained", 128'(ctl_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
